sprite_bitmap_loader: RTL and testbench

//   Write-side client of a sprite bitmap RAM (dual-address, 1-cycle sync read).

---
 rtl/sprite_pkg.sv | 15 +
 rtl/sprite_pixel_unpacker.sv | 55 +++++
 rtl/sprite_bitmap_loader.sv | 156 +++++++++++++++
 tb/tb_sprite_bitmap_loader.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared state encoding and sizing helper for the sprite bitmap loader.
package sprite_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FILL,
        S_DONE
    } loader_state_t;

    function automatic int pix_per_byte(input int dw);
        return 8 / dw;
    endfunction

endpackage

// File: rtl/sprite_pixel_unpacker.sv
// One-byte buffer that hands out packed pixels one per 'take', LSB pixel first.
module sprite_pixel_unpacker
    import sprite_pkg::*;
#(
    parameter int DATA_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  accept,
    input  logic [7:0]            s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  take,
    output logic [DATA_WIDTH-1:0] pixel,
    output logic                  pixel_valid
);

    localparam int PPB   = pix_per_byte(DATA_WIDTH);
    localparam int IDX_W = (PPB > 1) ? $clog2(PPB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PPB - 1);

    logic [7:0]       byte_q;
    logic [IDX_W-1:0] idx_q;
    logic             full_q;
    logic             last_slice;

    assign last_slice  = (idx_q == LAST_IDX);
    // Refill while the last slice leaves so consecutive bytes stream without a bubble.
    assign s_ready     = enable && accept && (!full_q || (take && last_slice));
    assign pixel_valid = full_q;
    assign pixel       = byte_q[DATA_WIDTH*idx_q +: DATA_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_q <= '0;
            idx_q  <= '0;
            full_q <= 1'b0;
        end else if (!enable) begin
            idx_q  <= '0;
            full_q <= 1'b0;
        end else if (s_valid && s_ready) begin
            byte_q <= s_data;
            idx_q  <= '0;
            full_q <= 1'b1;
        end else if (take) begin
            if (last_slice) begin
                full_q <= 1'b0;
            end else begin
                idx_q <= idx_q + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/sprite_bitmap_loader.sv
// Write-side sprite RAM client: unpacks a byte stream into pixels or floods one colour.
module sprite_bitmap_loader
    import sprite_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_load,
    input  logic                  start_fill,
    input  logic [DATA_WIDTH-1:0] fill_color,
    input  logic [7:0]            s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] addr_w,
    output logic [DATA_WIDTH-1:0] din,
    output logic                  busy,
    output logic                  done
);

    localparam int PPB    = pix_per_byte(DATA_WIDTH);
    localparam int NPIX   = 2 ** ADDR_WIDTH;
    localparam int NBYTES = (NPIX + PPB - 1) / PPB;
    localparam int CW     = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] LAST_PIX   = CW'(NPIX - 1);
    localparam logic [CW-1:0] BYTE_TOTAL = CW'(NBYTES);

    generate
        if (8 % DATA_WIDTH != 0) begin : g_bad_data_width
            $error("sprite_bitmap_loader: DATA_WIDTH must divide 8");
        end
    endgenerate

    loader_state_t         state_q, state_d;
    logic [CW-1:0]         pix_cnt_q;
    logic [CW-1:0]         byte_cnt_q;
    logic [DATA_WIDTH-1:0] fill_q;
    logic [DATA_WIDTH-1:0] pixel;
    logic                  pixel_valid;
    logic                  take;
    logic                  accept;
    logic                  wr_now;
    logic [DATA_WIDTH-1:0] wr_pix;
    logic                  cnt_clear;
    logic                  latch_fill;
    logic                  handshake;

    assign handshake = s_valid && s_ready;
    assign busy      = (state_q == S_LOAD) || (state_q == S_FILL);

    sprite_pixel_unpacker #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_unpacker (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (state_q == S_LOAD),
        .accept      (accept),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .take        (take),
        .pixel       (pixel),
        .pixel_valid (pixel_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Termination watches the pixel count, so excess pixels of a final partial byte are dropped.
    always_comb begin
        state_d    = state_q;
        take       = 1'b0;
        accept     = 1'b0;
        wr_now     = 1'b0;
        wr_pix     = '0;
        cnt_clear  = 1'b0;
        latch_fill = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_fill) begin
                    state_d    = S_FILL;
                    cnt_clear  = 1'b1;
                    latch_fill = 1'b1;
                end else if (start_load) begin
                    state_d   = S_LOAD;
                    cnt_clear = 1'b1;
                end
            end
            S_LOAD: begin
                accept = (byte_cnt_q != BYTE_TOTAL);
                if (pixel_valid) begin
                    take   = 1'b1;
                    wr_now = 1'b1;
                    wr_pix = pixel;
                    if (pix_cnt_q == LAST_PIX) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_FILL: begin
                wr_now = 1'b1;
                wr_pix = fill_q;
                if (pix_cnt_q == LAST_PIX) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we         <= 1'b0;
            addr_w     <= '0;
            din        <= '0;
            done       <= 1'b0;
            pix_cnt_q  <= '0;
            byte_cnt_q <= '0;
            fill_q     <= '0;
        end else begin
            we   <= wr_now;
            done <= (state_q == S_DONE);
            if (wr_now) begin
                addr_w <= pix_cnt_q[ADDR_WIDTH-1:0];
                din    <= wr_pix;
            end
            if (cnt_clear) begin
                pix_cnt_q  <= '0;
                byte_cnt_q <= '0;
            end else begin
                if (wr_now) begin
                    pix_cnt_q <= pix_cnt_q + CW'(1);
                end
                if (handshake) begin
                    byte_cnt_q <= byte_cnt_q + CW'(1);
                end
            end
            if (latch_fill) begin
                fill_q <= fill_color;
            end
        end
    end

endmodule

// File: tb/tb_sprite_bitmap_loader.sv
// Randomized bench for sprite_bitmap_loader against a pixel-list model and a RAM image.
module tb_sprite_bitmap_loader;

    localparam int AW     = 10;
    localparam int DW     = 2;
    localparam int NPIX   = 1024;
    localparam int PPB    = 4;
    localparam int NBYTES = 256;
    localparam int BNPIX  = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic          a_start_load, a_start_fill, a_s_valid, a_s_ready;
    logic [DW-1:0] a_fill_color, a_din;
    logic [7:0]    a_s_data;
    logic          a_we, a_busy, a_done;
    logic [AW-1:0] a_addr_w;

    logic       b_start_load, b_start_fill, b_s_valid, b_s_ready;
    logic [7:0] b_fill_color, b_din, b_s_data;
    logic       b_we, b_busy, b_done;
    logic [3:0] b_addr_w;

    sprite_bitmap_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start_load(a_start_load), .start_fill(a_start_fill),
        .fill_color(a_fill_color), .s_data(a_s_data), .s_valid(a_s_valid), .s_ready(a_s_ready),
        .we(a_we), .addr_w(a_addr_w), .din(a_din), .busy(a_busy), .done(a_done)
    );

    sprite_bitmap_loader #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start_load(b_start_load), .start_fill(b_start_fill),
        .fill_color(b_fill_color), .s_data(b_s_data), .s_valid(b_s_valid), .s_ready(b_s_ready),
        .we(b_we), .addr_w(b_addr_w), .din(b_din), .busy(b_busy), .done(b_done)
    );

    int checks   = 0;
    int failures = 0;
    int cyc_cnt  = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    logic [7:0]    bytes_q [0:NBYTES-1];
    logic [DW-1:0] exp_pix [0:NPIX-1];
    logic [DW-1:0] ram     [0:NPIX-1];
    logic [7:0]    bytes8  [0:BNPIX-1];

    int wr_cnt, addr_err, data_err, done_cnt, ready_cnt, next_addr;
    int first_wr_cyc, last_wr_cyc, done_cyc, late_ready;
    int b_wr_cnt, b_addr_err, b_data_err, b_done_cnt, b_next;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Reference write stream: every write must hit the next address with the modelled pixel.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (a_we === 1'b1) begin
                if (wr_cnt == 0) first_wr_cyc = cyc_cnt;
                last_wr_cyc = cyc_cnt;
                if (int'(a_addr_w) != next_addr) addr_err++;
                if (a_din !== exp_pix[a_addr_w]) data_err++;
                ram[a_addr_w] = a_din;
                next_addr++;
                wr_cnt++;
            end
            if (a_done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc_cnt;
            end
            if (a_s_ready === 1'b1) ready_cnt++;
            if (b_we === 1'b1) begin
                if (int'(b_addr_w) != b_next) b_addr_err++;
                if (b_din !== bytes8[b_addr_w]) b_data_err++;
                b_next++;
                b_wr_cnt++;
            end
            if (b_done === 1'b1) b_done_cnt++;
        end
    end

    task automatic clearMonitor();
        wr_cnt = 0; addr_err = 0; data_err = 0; done_cnt = 0; ready_cnt = 0; next_addr = 0;
        first_wr_cyc = 0; last_wr_cyc = 0; done_cyc = 0; late_ready = 0;
    endtask

    task automatic buildLoadModel(input bit force_e4);
        for (int b = 0; b < NBYTES; b++) bytes_q[b] = 8'($urandom);
        if (force_e4) bytes_q[0] = 8'hE4;
        for (int i = 0; i < NPIX; i++) begin
            exp_pix[i] = DW'((bytes_q[i / PPB] >> (DW * (i % PPB))) & 8'h03);
            ram[i]     = ~exp_pix[i];
        end
    endtask

    task automatic buildFillModel(input logic [DW-1:0] c);
        for (int i = 0; i < NPIX; i++) begin
            exp_pix[i] = c;
            ram[i]     = ~c;
        end
    endtask

    function automatic int ramMismatches();
        int n = 0;
        for (int i = 0; i < NPIX; i++) if (ram[i] !== exp_pix[i]) n++;
        return n;
    endfunction

    task automatic applyStimulus(input logic ld, input logic fl, input logic [DW-1:0] c);
        a_start_load = ld;
        a_start_fill = fl;
        a_fill_color = c;
        @(posedge clk);
        #1;
        a_start_load = 1'b0;
        a_start_fill = 1'b0;
        a_fill_color = ~c;
    endtask

    task automatic streamBytes(input int n, input int gap_pct, input int budget);
        int idx = 0;
        int c   = 0;
        while (idx < n && c < budget) begin
            a_s_valid = ($urandom_range(99) >= gap_pct);
            a_s_data  = bytes_q[idx];
            @(negedge clk);
            if (a_s_valid && a_s_ready) idx++;
            @(posedge clk);
            #1;
            c++;
        end
        a_s_valid = 1'b0;
        checkOutput("stream_bytes_accepted", idx, n);
    endtask

    task automatic waitDone(input string tag, input int budget);
        int c = 0;
        late_ready = 0;
        while (done_cnt == 0 && c < budget) begin
            @(posedge clk);
            #1;
            if (a_s_ready === 1'b1) late_ready++;
            c++;
        end
        checkOutput({tag, "_done_in_time"}, (done_cnt != 0), 1);
        repeat (4) @(posedge clk);
        #1;
        checkOutput({tag, "_busy_after"}, a_busy, 0);
    endtask

    task automatic checkFullSprite(input string tag);
        checkOutput({tag, "_writes"}, wr_cnt, NPIX);
        checkOutput({tag, "_addr_seq_err"}, addr_err, 0);
        checkOutput({tag, "_data_err"}, data_err, 0);
        checkOutput({tag, "_done_pulses"}, done_cnt, 1);
        checkOutput({tag, "_ram_mismatch"}, ramMismatches(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int start_edge, idx, c, stalls;
        logic [DW-1:0] color;

        rst_n = 1'b0;
        a_start_load = 0; a_start_fill = 0; a_fill_color = '0; a_s_data = '0; a_s_valid = 0;
        b_start_load = 0; b_start_fill = 0; b_fill_color = '0; b_s_data = '0; b_s_valid = 0;
        clearMonitor();
        b_wr_cnt = 0; b_addr_err = 0; b_data_err = 0; b_done_cnt = 0; b_next = 0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_we", a_we, 0);
        checkOutput("rst_addr_w", a_addr_w, 0);
        checkOutput("rst_din", a_din, 0);
        checkOutput("rst_s_ready", a_s_ready, 0);
        checkOutput("rst_busy", a_busy, 0);
        checkOutput("rst_done", a_done, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] back-to-back load, first byte 0xE4");
        buildLoadModel(1'b1);
        clearMonitor();
        applyStimulus(1'b1, 1'b0, '0);
        checkOutput("t1_busy", a_busy, 1);
        streamBytes(NBYTES, 0, 4000);
        waitDone("t1", 3000);
        checkFullSprite("t1");
        checkOutput("t1_write_span", last_wr_cyc - first_wr_cyc + 1, NPIX);
        checkOutput("t1_ram0", ram[0], 0);
        checkOutput("t1_ram1", ram[1], 1);
        checkOutput("t1_ram2", ram[2], 2);
        checkOutput("t1_ram3", ram[3], 3);
        checkOutput("t1_ready_after_last", late_ready, 0);

        $display("[TB] load with random valid gaps");
        buildLoadModel(1'b0);
        clearMonitor();
        applyStimulus(1'b1, 1'b0, '0);
        streamBytes(NBYTES, 50, 8000);
        waitDone("t2", 3000);
        checkFullSprite("t2");

        $display("[TB] flood fill with colour 2");
        buildFillModel(2'b10);
        clearMonitor();
        start_edge = cyc_cnt + 1;
        applyStimulus(1'b0, 1'b1, 2'b10);
        checkOutput("t3_busy", a_busy, 1);
        waitDone("t3", 2000);
        checkFullSprite("t3");
        checkOutput("t3_first_write_latency", first_wr_cyc - start_edge, 1);
        checkOutput("t3_done_latency", done_cyc - start_edge, NPIX + 1);

        $display("[TB] simultaneous starts and start_load during fill");
        color = DW'($urandom);
        buildFillModel(color);
        clearMonitor();
        a_s_valid = 1'b1;
        a_s_data  = 8'($urandom);
        applyStimulus(1'b1, 1'b1, color);
        repeat (300) @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b0, color);
        waitDone("t4", 2000);
        a_s_valid = 1'b0;
        checkFullSprite("t4");
        checkOutput("t4_s_ready_seen", ready_cnt, 0);

        $display("[TB] async reset mid-load, then reload");
        buildLoadModel(1'b0);
        clearMonitor();
        applyStimulus(1'b1, 1'b0, '0);
        streamBytes(100, 0, 1000);
        checkOutput("t5_pre_addr_err", addr_err, 0);
        checkOutput("t5_pre_data_err", data_err, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t5_rst_we", a_we, 0);
        checkOutput("t5_rst_addr_w", a_addr_w, 0);
        checkOutput("t5_rst_din", a_din, 0);
        checkOutput("t5_rst_s_ready", a_s_ready, 0);
        checkOutput("t5_rst_busy", a_busy, 0);
        #4;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        buildLoadModel(1'b0);
        clearMonitor();
        applyStimulus(1'b1, 1'b0, '0);
        streamBytes(NBYTES, 25, 6000);
        waitDone("t5", 3000);
        checkFullSprite("t5");

        $display("[TB] 8-bit pixels, 16-entry sprite");
        for (int i = 0; i < BNPIX; i++) bytes8[i] = 8'($urandom);
        b_start_load = 1'b1;
        @(posedge clk);
        #1;
        b_start_load = 1'b0;
        idx = 0; c = 0; stalls = 0;
        while (idx < BNPIX && c < 100) begin
            b_s_valid = 1'b1;
            b_s_data  = bytes8[idx];
            @(negedge clk);
            if (b_s_ready === 1'b1) idx++;
            else stalls++;
            @(posedge clk);
            #1;
            c++;
        end
        b_s_valid = 1'b0;
        checkOutput("t6_bytes_accepted", idx, BNPIX);
        checkOutput("t6_ready_stalls", stalls, 0);
        checkOutput("t6_ready_after_last", b_s_ready, 0);
        c = 0;
        while (b_done_cnt == 0 && c < 100) begin
            @(posedge clk);
            #1;
            c++;
        end
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t6_writes", b_wr_cnt, BNPIX);
        checkOutput("t6_addr_seq_err", b_addr_err, 0);
        checkOutput("t6_data_err", b_data_err, 0);
        checkOutput("t6_done_pulses", b_done_cnt, 1);
        checkOutput("t6_busy_after", b_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
